// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// apb_pkg : APB transfer states and default bus widths shared by the master
//           and the APB slave peripherals.
// Rev 1.0
// ============================================================================
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 8;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// apb_wait_timer : saturating count of ACCESS wait cycles; flags the cycle in
//                  which the count reaches TIMEOUT (never when TIMEOUT is 0).
// Rev 1.0
// ============================================================================
module apb_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Asserted during the wait cycle whose increment makes the count hit TIMEOUT.
   assign expired = (TIMEOUT != 0) && enable && (count_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// apb_master : single-outstanding APB3 requester bridging a valid/ready
//              command/response pair to one SETUP+ACCESS transfer.
// Rev 1.0
// ============================================================================
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = APB_ADDR_W,
   parameter int unsigned DATA_W  = APB_DATA_W,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rst_hold_q;
   logic              timer_clear;
   logic              timer_enable;
   logic              timer_expired;

   assign timer_clear  = (state_q == SETUP);
   assign timer_enable = (state_q == ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (PCLK),
      .rst     (PRESET),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Registered copy of PRESET keeps cmd_ready low while reset is held
   // without a combinational path from the reset input.
   assign cmd_ready = (state_q == IDLE) && !rst_hold_q;
   assign rsp_valid = (state_q == RESP);
   assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
   assign PENABLE   = (state_q == ACCESS);
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
               err_d   = PSLVERR;
               state_d = RESP;
            end else if (timer_expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      rst_hold_q <= PRESET;
      if (PRESET) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// tb_apb_master : directed scoreboard bench for apb_master (TIMEOUT=16 and 0).
// Rev 1.0
// ============================================================================
module tb_apb_master;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cmd_valid, cmd_valid_b, cmd_write, rsp_ready, pready, pslverr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata, prdata;

   logic          cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [DW-1:0] rsp_rdata, pwdata;
   logic [AW-1:0] paddr;

   logic          cmd_ready_b, rsp_valid_b, rsp_err_b, psel_b, penable_b, pwrite_b;
   logic [DW-1:0] rsp_rdata_b, pwdata_b;
   logic [AW-1:0] paddr_b;

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .PCLK(clk), .PRESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut_b (
      .PCLK(clk), .PRESET(rst),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
      .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PADDR(paddr_b), .PWDATA(pwdata_b),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Offer one command at a negedge in IDLE, return at the SETUP negedge.
   task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      chk("idle_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, wr);
   endtask

   task automatic expect_rsp(input string tag);
      exp_t e;
      chk({tag, "_valid"}, rsp_valid, 1);
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL %s_queue: observed response expected none pending", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, rsp_rdata, e.rdata);
         chk({tag, "_err"}, rsp_err, e.err);
      end
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      expect_rsp(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic seen;
      rst = 1'b1; cmd_valid = 1'b0; cmd_valid_b = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1; pready = 1'b1;
      pslverr = 1'b0; prdata = '0;
      repeat (3) tick();

      // Reset state while PRESET is still held
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // Zero-wait write
      prdata = 32'h1111_2222;
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 8'h10, 32'hDEAD_BEEF);
      tick();
      chk("wr_acc_psel", psel, 1);
      chk("wr_acc_penable", penable, 1);
      chk("wr_acc_paddr", paddr, 8'h10);
      chk("wr_acc_pwrite", pwrite, 1);
      chk("wr_acc_pwdata", pwdata, 32'hDEAD_BEEF);
      chk("wr_acc_rsp_valid", rsp_valid, 0);
      tick();
      expect_rsp("wr");
      chk("wr_resp_psel", psel, 0);
      chk("wr_resp_cmd_ready", cmd_ready, 0);
      tick();
      chk("wr_idle_cmd_ready", cmd_ready, 1);
      chk("wr_idle_rsp_valid", rsp_valid, 0);
      chk("wr_idle_paddr_hold", paddr, 8'h10);

      // Read with three wait states
      pready = 1'b0;
      prdata = 32'hDEAD_BEEF;
      sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      send(1'b0, 8'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rdw_penable", penable, 1);
         chk("rdw_paddr", paddr, 8'h10);
         chk("rdw_pwrite", pwrite, 0);
         chk("rdw_rsp_valid", rsp_valid, 0);
         if (i == 3) pready = 1'b1;
      end
      tick();
      expect_rsp("rd_wait");
      tick();
      chk("rdw_idle_cmd_ready", cmd_ready, 1);

      // PSLVERR read, response back-pressured for five cycles
      pslverr = 1'b1;
      prdata = 32'h1234_5678;
      rsp_ready = 1'b0;
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      send(1'b0, 8'h24, 32'h0);
      tick();
      tick();
      pslverr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_rdata", rsp_rdata, 0);
         chk("hold_rsp_err", rsp_err, 1);
         chk("hold_cmd_ready", cmd_ready, 0);
         prdata = $urandom;
         tick();
      end
      rsp_ready = 1'b1;
      expect_rsp("slverr");
      tick();
      chk("slverr_idle_cmd_ready", cmd_ready, 1);
      chk("slverr_idle_rsp_valid", rsp_valid, 0);

      // Timeout with PREADY stuck low
      pready = 1'b0;
      prdata = 32'hA5A5_A5A5;
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      send(1'b0, 8'h20, 32'h0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("to_access", {psel, penable}, 2'b11);
         chk("to_rsp_valid", rsp_valid, 0);
      end
      tick();
      expect_rsp("timeout");
      chk("to_resp_penable", penable, 0);
      tick();
      chk("to_idle_cmd_ready", cmd_ready, 1);

      // Reset during ACCESS
      send(1'b1, 8'h30, 32'h0BAD_F00D);
      tick();
      chk("rstacc_penable", penable, 1);
      rst = 1'b1;
      tick();
      chk("rstacc_psel", psel, 0);
      chk("rstacc_penable_low", penable, 0);
      chk("rstacc_rsp_valid", rsp_valid, 0);
      chk("rstacc_cmd_ready", cmd_ready, 0);
      chk("rstacc_paddr", paddr, 0);
      rst = 1'b0;
      pready = 1'b1;
      tick();
      chk("rstacc_cmd_ready_back", cmd_ready, 1);
      chk("rstacc_no_rsp", rsp_valid, 0);
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 8'h44, 32'h55AA_55AA);
      wait_rsp("post_reset", 8);
      tick();
      chk("post_reset_idle", cmd_ready, 1);

      // TIMEOUT=0 instance waits indefinitely
      pready = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = 8'h55;
      cmd_valid_b = 1'b1;
      chk("nto_cmd_ready", cmd_ready_b, 1);
      tick();
      cmd_valid_b = 1'b0;
      chk("nto_setup_psel", psel_b, 1);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (rsp_valid_b) seen = 1'b1;
      end
      chk("nto_no_rsp", seen, 0);
      chk("nto_still_access", {psel_b, penable_b}, 2'b11);
      prdata = 32'hCAFE_F00D;
      pready = 1'b1;
      tick();
      chk("nto_rsp_valid", rsp_valid_b, 1);
      chk("nto_rsp_rdata", rsp_rdata_b, 32'hCAFE_F00D);
      chk("nto_rsp_err", rsp_err_b, 0);

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_master.md
# apb_master

Requester-side APB3 bridge: accepts single read/write commands on a valid/ready interface, drives one APB transfer (SETUP then ACCESS, with wait states), and returns read data and error status on a valid/ready response interface. It sits between an internal controller or test sequencer and the team's APB slave peripherals, with one transfer outstanding at a time.

## Interface
- ADDR_W, 8, PADDR / cmd_addr width
- DATA_W, 32, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W;  PWDATA  out  DATA_W
- PRDATA  in  DATA_W;  PREADY  in  1;  PSLVERR  in  1  (tie PREADY=1, PSLVERR=0 for zero-wait slaves)

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA, -> SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle only, -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1: capture PRDATA (reads; 0 for writes) into rsp_rdata, PSLVERR into rsp_err, -> RESP. PREADY=0: wait-counter increments; when TIMEOUT!=0 and counter reaches TIMEOUT, rsp_err=1, rsp_rdata=0, -> RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready -> IDLE.
- PADDR, PWRITE, PWDATA stable from SETUP through ACCESS completion; hold value in RESP/IDLE (no toggling).
- cmd_ready=0 in SETUP, ACCESS, RESP, and while PRESET=1. Commands presented then are not consumed.
- PSLVERR ignored except at PREADY=1 in ACCESS.
- Wait-counter clears on entry to SETUP; width clog2(TIMEOUT+1), saturating.

## Timing
- Reset (PRESET=1 at an edge): state IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Outputs registered; effective from that edge.
- Reset mid-transfer: abort immediately, no response issued, PSEL drops after the reset edge.
- Zero-wait transfer: handshake at edge k; SETUP cycle k+1; ACCESS cycle k+2; rsp_valid high from k+3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Timeout: with PREADY stuck low, ACCESS lasts exactly TIMEOUT cycles; rsp_valid high the next cycle.
- rsp_ready already high when rsp_valid rises: RESP lasts one cycle; cmd_ready high the next cycle. Minimum command spacing 4 cycles.
- cmd_ready and rsp_valid are decoded from registered state only (no input-to-output combinational path).

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default ADDR_W/DATA_W constants, shared with the slave peripherals.
- One sub-module: apb_wait_timer (clear, enable, TIMEOUT parameter, expired output).

## Test plan
- Write 0xDEADBEEF to 0x10, PREADY=1 -> SETUP at k+1, ACCESS at k+2 with PADDR=0x10, PWRITE=1; rsp_valid k+3, rsp_err=0, rsp_rdata=0.
- Read 0x10, slave drives PRDATA=0xDEADBEEF, PREADY low 3 cycles -> ACCESS 4 cycles, PADDR/PWRITE stable, rsp_rdata=0xDEADBEEF.
- Read with PREADY=1, PSLVERR=1 -> rsp_err=1; rsp held 5 cycles with rsp_ready=0, values unchanged, cmd_ready=0 throughout.
- TIMEOUT=16, PREADY stuck low -> exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; TIMEOUT=0 -> waits indefinitely (check 100 cycles).
- PRESET asserted in ACCESS -> next cycle PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1 one cycle after PRESET drops; next command completes normally.
